// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg
// Description : Shared defaults, port indices and grant-FSM encoding for the
//               two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

    localparam int c_DEF_BITS         = 16;
    localparam int c_DEF_ADDRESS_BITS = 15;
    localparam int c_DEF_BURST_LEN    = 4;

    localparam logic c_PORT0 = 1'b0;
    localparam logic c_PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t own_state(input logic port);
        return port ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_if
// Description : Request ports, read-return ports and memory-side bus of the
//               two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if
    import memory_pkg::*;
#(
    parameter int BITS         = c_DEF_BITS,
    parameter int ADDRESS_BITS = c_DEF_ADDRESS_BITS
);
    logic                    REQ0_VALID;
    logic                    REQ0_WR;
    logic [ADDRESS_BITS-1:0] REQ0_ADDR;
    logic [BITS-1:0]         REQ0_WDATA;
    logic                    REQ0_READY;
    logic [BITS-1:0]         RD0_DATA;
    logic                    RD0_VALID;

    logic                    REQ1_VALID;
    logic                    REQ1_WR;
    logic [ADDRESS_BITS-1:0] REQ1_ADDR;
    logic [BITS-1:0]         REQ1_WDATA;
    logic                    REQ1_READY;
    logic [BITS-1:0]         RD1_DATA;
    logic                    RD1_VALID;

    logic [ADDRESS_BITS-1:0] MEM_ADDRESS;
    logic [BITS-1:0]         MEM_DATA_IN;
    logic                    MEM_WR;
    logic [BITS-1:0]         MEM_DATA_OUT;

    modport slave (
        input  REQ0_VALID, REQ0_WR, REQ0_ADDR, REQ0_WDATA,
        input  REQ1_VALID, REQ1_WR, REQ1_ADDR, REQ1_WDATA,
        input  MEM_DATA_OUT,
        output REQ0_READY, RD0_DATA, RD0_VALID,
        output REQ1_READY, RD1_DATA, RD1_VALID,
        output MEM_ADDRESS, MEM_DATA_IN, MEM_WR
    );

    modport master (
        output REQ0_VALID, REQ0_WR, REQ0_ADDR, REQ0_WDATA,
        output REQ1_VALID, REQ1_WR, REQ1_ADDR, REQ1_WDATA,
        output MEM_DATA_OUT,
        input  REQ0_READY, RD0_DATA, RD0_VALID,
        input  REQ1_READY, RD1_DATA, RD1_VALID,
        input  MEM_ADDRESS, MEM_DATA_IN, MEM_WR
    );

endinterface
`default_nettype wire

// File: rtl/arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : arb_grant
// Description : Two-port grant FSM with burst counter. MEMORY_ARBITER_ROUND_ROBIN_EN
//               selects alternating tie-break with burst limit; otherwise port 0
//               has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_grant
    import memory_pkg::*;
#(
    parameter int BURST_LEN = c_DEF_BURST_LEN
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_valid,
    output logic      [1:0] o_ready
);

    localparam int                 c_CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_BURST = c_CNT_W'(BURST_LEN);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_own;
    logic               w_oth;
    logic               w_pref;
    logic               w_yield;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic               r_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            r_last  <= c_PORT1;   // port 0 wins the first tie after reset
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            if (o_ready != 2'b00) begin
                r_last <= o_ready[1];
            end
`endif
        end
    end

    always_comb begin
        o_ready     = 2'b00;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_own       = (r_state == ST_OWN1);
        w_oth       = ~w_own;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        w_pref      = ~r_last;
        w_yield     = (r_cnt >= c_BURST) && i_valid[w_oth];
`else
        w_pref      = c_PORT0;
        // port 0 preempts an ongoing port-1 ownership immediately
        w_yield     = w_own && i_valid[c_PORT0];
`endif

        case (r_state)
            ST_IDLE: begin
                if (i_valid[w_pref]) begin
                    o_ready[w_pref] = 1'b1;
                    w_state_nxt     = own_state(w_pref);
                    w_cnt_nxt       = c_ONE;
                end else if (i_valid[~w_pref]) begin
                    o_ready[~w_pref] = 1'b1;
                    w_state_nxt      = own_state(~w_pref);
                    w_cnt_nxt        = c_ONE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (i_valid[w_own] && !w_yield) begin
                    o_ready[w_own] = 1'b1;
                    w_cnt_nxt      = (r_cnt >= c_BURST) ? r_cnt : r_cnt + 1'b1;
                end else if (i_valid[w_oth]) begin
                    o_ready[w_oth] = 1'b1;
                    w_state_nxt    = own_state(w_oth);
                    w_cnt_nxt      = c_ONE;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_cnt_nxt      = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (rst) begin
            o_ready = 2'b00;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Two-port single-memory arbiter: request mux and 2-cycle read
//               return. Macro MEMORY_ARBITER_ROUND_ROBIN_EN enables round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int BITS         = c_DEF_BITS,
    parameter int ADDRESS_BITS = c_DEF_ADDRESS_BITS,
    parameter int BURST_LEN    = c_DEF_BURST_LEN
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    memory_arbiter_if.slave bus
);

    logic [1:0]              w_valid;
    logic [1:0]              w_ready;
    logic [1:0]              w_xfer;
    logic [ADDRESS_BITS-1:0] w_mem_addr;
    logic [BITS-1:0]         w_mem_din;
    logic                    w_mem_wr;

    logic                    r_pend_vld;
    logic                    r_pend_port;
    logic [1:0]              r_rd_vld;
    logic [BITS-1:0]         r_rd_data0;
    logic [BITS-1:0]         r_rd_data1;

    assign w_valid = {bus.REQ1_VALID, bus.REQ0_VALID};
    assign w_xfer  = w_valid & w_ready;

    arb_grant #(
        .BURST_LEN (BURST_LEN)
    ) u_grant (
        .clk     (CLK),
        .rst     (RST),
        .i_valid (w_valid),
        .o_ready (w_ready)
    );

    assign bus.REQ0_READY = w_ready[c_PORT0];
    assign bus.REQ1_READY = w_ready[c_PORT1];

    always_comb begin
        w_mem_addr = '0;
        w_mem_din  = '0;
        w_mem_wr   = 1'b0;
        if (w_xfer[c_PORT0]) begin
            w_mem_addr = bus.REQ0_ADDR;
            w_mem_din  = bus.REQ0_WDATA;
            w_mem_wr   = bus.REQ0_WR;
        end else if (w_xfer[c_PORT1]) begin
            w_mem_addr = bus.REQ1_ADDR;
            w_mem_din  = bus.REQ1_WDATA;
            w_mem_wr   = bus.REQ1_WR;
        end
    end

    assign bus.MEM_ADDRESS = w_mem_addr;
    assign bus.MEM_DATA_IN = w_mem_din;
    assign bus.MEM_WR      = w_mem_wr;

    // Stage 1 tags the read issued this cycle; stage 2 captures the memory's
    // registered output one cycle later and raises the port's valid pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend_vld  <= 1'b0;
            r_pend_port <= 1'b0;
            r_rd_vld    <= 2'b00;
            r_rd_data0  <= '0;
            r_rd_data1  <= '0;
        end else begin
            r_pend_vld  <= (|w_xfer) && !w_mem_wr;
            r_pend_port <= w_xfer[c_PORT1];
            r_rd_vld    <= 2'b00;
            if (r_pend_vld) begin
                r_rd_vld[r_pend_port] <= 1'b1;
                if (r_pend_port) begin
                    r_rd_data1 <= bus.MEM_DATA_OUT;
                end else begin
                    r_rd_data0 <= bus.MEM_DATA_OUT;
                end
            end
        end
    end

    assign bus.RD0_VALID = r_rd_vld[c_PORT0];
    assign bus.RD1_VALID = r_rd_vld[c_PORT1];
    assign bus.RD0_DATA  = r_rd_data0;
    assign bus.RD1_DATA  = r_rd_data1;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Scoreboard bench for memory_arbiter with a synchronous memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int c_BITS  = 16;
    localparam int c_AB    = 15;
    localparam int c_BURST = 4;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        logic        chk;
    } cmd_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    cmd_t cq0[$];
    cmd_t cq1[$];
    exp_t sb0[$];
    exp_t sb1[$];
    int   glog_port[$];
    int   glog_cyc[$];
    logic [15:0] mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_arbiter_if #(.BITS(c_BITS), .ADDRESS_BITS(c_AB)) bus ();

    memory_arbiter #(
        .BITS         (c_BITS),
        .ADDRESS_BITS (c_AB),
        .BURST_LEN    (c_BURST)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    function automatic logic [15:0] init_word(input int a);
        case (a)
            32'h0003: return 16'h0C03;
            32'h0010: return 16'hAAAA;
            32'h0020: return 16'h5555;
            default:  return 16'h0000;
        endcase
    endfunction

    // Synchronous-read memory: address registered at the transfer edge.
    always @(posedge clk) begin : mem_model
        int a;
        a = int'(bus.MEM_ADDRESS);
        bus.MEM_DATA_OUT <= mem.exists(a) ? mem[a] : init_word(a);
        if (bus.MEM_WR) mem[a] = bus.MEM_DATA_IN;
    end

    function automatic cmd_t mk(input logic wr, input logic [14:0] addr, input logic [15:0] wd,
                                input logic [15:0] exp, input logic chk);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wd; c.exp = exp; c.chk = chk;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic set_req(input int p, input logic v, input cmd_t c);
        if (p == 0) begin
            bus.REQ0_VALID = v; bus.REQ0_WR = c.wr; bus.REQ0_ADDR = c.addr; bus.REQ0_WDATA = c.wdata;
        end else begin
            bus.REQ1_VALID = v; bus.REQ1_WR = c.wr; bus.REQ1_ADDR = c.addr; bus.REQ1_WDATA = c.wdata;
        end
    endtask

    task automatic drive_port(input int p);
        cmd_t c;
        cmd_t c_idle;
        int   waited;
        c_idle = mk(1'b0, 15'h0, 16'h0, 16'h0, 1'b0);
        waited = 0;
        forever begin
            @(posedge clk);
            #1;
            if ((p == 0 ? cq0.size() : cq1.size()) == 0) begin
                set_req(p, 1'b0, c_idle);
            end else begin
                c = (p == 0) ? cq0[0] : cq1[0];
                set_req(p, 1'b1, c);
                @(negedge clk);
                if ((p == 0) ? bus.REQ0_READY : bus.REQ1_READY) begin
                    if (p == 0) void'(cq0.pop_front()); else void'(cq1.pop_front());
                    glog_port.push_back(p);
                    glog_cyc.push_back(cyc);
                    if (!c.wr && c.chk) begin
                        if (p == 0) sb0.push_back('{c.exp, cyc + 2});
                        else        sb1.push_back('{c.exp, cyc + 2});
                    end
                    waited = 0;
                end else begin
                    waited++;
                    if (waited > 200) begin
                        n_checks++; n_errors++;
                        $display("FAIL grant_timeout port%0d: no READY after %0d cycles, required a grant", p, waited);
                        if (p == 0) void'(cq0.pop_front()); else void'(cq1.pop_front());
                        waited = 0;
                    end
                end
            end
        end
    endtask

    initial drive_port(0);
    initial drive_port(1);

    task automatic rd_check(input int p, input logic [15:0] d);
        exp_t e;
        if ((p == 0 ? sb0.size() : sb1.size()) == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rd%0d_unexpected: RD_VALID high with data %h, required no response (cycle %0d)", p, d, cyc);
        end else begin
            if (p == 0) e = sb0.pop_front(); else e = sb1.pop_front();
            check($sformatf("rd%0d_data", p), 32'(d), 32'(e.data));
            check($sformatf("rd%0d_latency_cycle", p), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.RD0_VALID) rd_check(0, bus.RD0_DATA);
        if (bus.RD1_VALID) rd_check(1, bus.RD1_DATA);
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((cq0.size() + cq1.size() + sb0.size() + sb1.size()) != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (k >= 300) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: %0d items outstanding, required 0",
                     cq0.size() + cq1.size() + sb0.size() + sb1.size());
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_grants(input string name, input int base, input int exp_p[$]);
        for (int i = 0; i < exp_p.size(); i++) begin
            if (base + i >= glog_port.size()) begin
                n_checks++; n_errors++;
                $display("FAIL %s_missing: grant %0d absent, required port %0d", name, i, exp_p[i]);
            end else begin
                check($sformatf("%s_port[%0d]", name, i), glog_port[base + i], exp_p[i]);
                if (i > 0)
                    check($sformatf("%s_cycle[%0d]", name, i), glog_cyc[base + i], glog_cyc[base] + i);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready1"}, 32'(bus.REQ1_READY), 32'h0);
        check({tag, "_mem_wr"}, 32'(bus.MEM_WR), 32'h0);
        check({tag, "_mem_addr"}, 32'(bus.MEM_ADDRESS), 32'h0);
        check({tag, "_rd0_valid"}, 32'(bus.RD0_VALID), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int k;
        int e_alt[$];
        int e_burst[$];

        bus.REQ0_VALID = 1'b0; bus.REQ0_WR = 1'b0; bus.REQ0_ADDR = '0; bus.REQ0_WDATA = '0;
        bus.REQ1_VALID = 1'b0; bus.REQ1_WR = 1'b0; bus.REQ1_ADDR = '0; bus.REQ1_WDATA = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready0",    32'(bus.REQ0_READY), 32'h0);
        check("reset_ready1",    32'(bus.REQ1_READY), 32'h0);
        check("reset_rd0_valid", 32'(bus.RD0_VALID), 32'h0);
        check("reset_rd1_valid", 32'(bus.RD1_VALID), 32'h0);
        check("reset_rd0_data",  32'(bus.RD0_DATA), 32'h0);
        check("reset_rd1_data",  32'(bus.RD1_DATA), 32'h0);
        check("reset_mem_addr",  32'(bus.MEM_ADDRESS), 32'h0);
        check("reset_mem_din",   32'(bus.MEM_DATA_IN), 32'h0);
        check("reset_mem_wr",    32'(bus.MEM_WR), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back on port 0
        @(negedge clk);
        cq0.push_back(mk(1'b1, 15'h0005, 16'h1234, 16'h0000, 1'b0));
        cq0.push_back(mk(1'b0, 15'h0005, 16'h0000, 16'h1234, 1'b1));
        wait_idle();

        // Bank bit 14 must not alias into the lower bank
        @(negedge clk);
        cq1.push_back(mk(1'b1, 15'h4003, 16'hBEEF, 16'h0000, 1'b0));
        wait_idle();
        @(negedge clk);
        cq0.push_back(mk(1'b0, 15'h0003, 16'h0000, 16'h0C03, 1'b1));
        wait_idle();
        @(negedge clk);
        cq1.push_back(mk(1'b0, 15'h4003, 16'h0000, 16'hBEEF, 1'b1));
        wait_idle();
        @(negedge clk);
        check("rd0_data_hold", 32'(bus.RD0_DATA), 32'h0C03);

        // Simultaneous reads; port 0 drops VALID at count 2, port 1 takes over
        n = glog_port.size();
        cq0.push_back(mk(1'b0, 15'h0010, 16'h0000, 16'hAAAA, 1'b1));
        cq0.push_back(mk(1'b0, 15'h0010, 16'h0000, 16'hAAAA, 1'b1));
        cq1.push_back(mk(1'b0, 15'h0020, 16'h0000, 16'h5555, 1'b1));
        cq1.push_back(mk(1'b0, 15'h0020, 16'h0000, 16'h5555, 1'b1));
        wait_idle();
        e_alt = {0, 0, 1, 1};
        check_grants("handover", n, e_alt);

        // Both ports continuously valid
        @(negedge clk);
        n = glog_port.size();
        for (int i = 0; i < 10; i++) begin
            cq0.push_back(mk(1'b0, 15'h0005, 16'h0000, 16'h1234, 1'b1));
            cq1.push_back(mk(1'b0, 15'h4003, 16'h0000, 16'hBEEF, 1'b1));
        end
        wait_idle();
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        e_burst = {0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
`else
        e_burst = {0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
        check_grants("burst", n, e_burst);

        // Reset the cycle after a read transfer: the read must be discarded
        @(negedge clk);
        n = glog_port.size();
        cq0.push_back(mk(1'b0, 15'h0010, 16'h0000, 16'h0000, 1'b0));
        k = 0;
        while (glog_port.size() == n && k < 50) begin
            @(posedge clk);
            k++;
        end
        check("rst_read_transferred", glog_port.size(), n + 1);
        #1 rst = 1'b1;
        cq1.push_back(mk(1'b1, 15'h0100, 16'h7777, 16'h0000, 1'b0));
        @(negedge clk);
        check_quiet("in_rst_a");
        @(negedge clk);
        check_quiet("in_rst_b");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_rd0_valid_a", 32'(bus.RD0_VALID), 32'h0);
        check("post_rst_rd1_valid_a", 32'(bus.RD1_VALID), 32'h0);
        @(negedge clk);
        check("post_rst_rd0_valid_b", 32'(bus.RD0_VALID), 32'h0);
        check("post_rst_rd1_valid_b", 32'(bus.RD1_VALID), 32'h0);
        wait_idle();

        // Request held through reset is accepted afterwards, exactly once
        @(negedge clk);
        cq1.push_back(mk(1'b0, 15'h0100, 16'h0000, 16'h7777, 1'b1));
        wait_idle();

        check("queues_empty", cq0.size() + cq1.size() + sb0.size() + sb1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
